wb_reg_file: RTL and testbench



---
 rtl/wb_reg_file.sv | 76 +++++++
 tb/tb_wb_reg_file.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/wb_reg_file.sv
// Register file fed by the WB stage with two ID read ports and one debug read port.
// Define REGFILE_BYPASS_EN to expose the same-cycle WB write on the ID read ports.
module wb_reg_file #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] WB_Reg_WriteAddr,
  input  logic              WB_Reg_WriteEn,
  input  logic [DATA_W-1:0] WB_Reg_WriteData,
  input  logic [ADDR_W-1:0] ID_Reg_ReadAddr1,
  input  logic              ID_Reg_ReadEn1,
  output logic [DATA_W-1:0] ID_Reg_ReadData1,
  input  logic [ADDR_W-1:0] ID_Reg_ReadAddr2,
  input  logic              ID_Reg_ReadEn2,
  output logic [DATA_W-1:0] ID_Reg_ReadData2,
  input  logic [ADDR_W-1:0] Dbg_ReadAddr,
  output logic [DATA_W-1:0] Dbg_ReadData,
  output logic [15:0]       Wr_Count
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [15:0]       wr_count_q, wr_count_d;
  logic              wr_commit;

  assign wr_commit = !rst && WB_Reg_WriteEn && (WB_Reg_WriteAddr != '0);

  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (rst) begin
      regs_d     = '{default: '0};
      wr_count_d = '0;
    end else if (wr_commit) begin
      regs_d[WB_Reg_WriteAddr] = WB_Reg_WriteData;
      wr_count_d               = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    wr_count_q <= wr_count_d;
  end

  logic byp1, byp2;
`ifdef REGFILE_BYPASS_EN
  // wr_commit already excludes rst and address 0, matching the bypass conditions.
  assign byp1 = wr_commit && (WB_Reg_WriteAddr == ID_Reg_ReadAddr1);
  assign byp2 = wr_commit && (WB_Reg_WriteAddr == ID_Reg_ReadAddr2);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_comb begin
    ID_Reg_ReadData1 = '0;
    if (ID_Reg_ReadEn1 && (ID_Reg_ReadAddr1 != '0)) begin
      ID_Reg_ReadData1 = byp1 ? WB_Reg_WriteData : regs_q[ID_Reg_ReadAddr1];
    end
  end

  always_comb begin
    ID_Reg_ReadData2 = '0;
    if (ID_Reg_ReadEn2 && (ID_Reg_ReadAddr2 != '0)) begin
      ID_Reg_ReadData2 = byp2 ? WB_Reg_WriteData : regs_q[ID_Reg_ReadAddr2];
    end
  end

  // Register 0 is never written, so storage already reads 0 there.
  assign Dbg_ReadData = regs_q[Dbg_ReadAddr];
  assign Wr_Count     = wr_count_q;

endmodule

// File: tb/tb_wb_reg_file.sv
// Randomised self-checking bench for wb_reg_file against an array-based reference model.
module tb_wb_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  wa, a1, a2, da;
  logic        we, e1, e2;
  logic [31:0] wd;
  logic [31:0] rd1, rd2, dbg;
  logic [15:0] cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  logic [31:0] m_regs [32];
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  wb_reg_file dut (
    .clk              (clk),
    .rst              (rst),
    .WB_Reg_WriteAddr (wa),
    .WB_Reg_WriteEn   (we),
    .WB_Reg_WriteData (wd),
    .ID_Reg_ReadAddr1 (a1),
    .ID_Reg_ReadEn1   (e1),
    .ID_Reg_ReadData1 (rd1),
    .ID_Reg_ReadAddr2 (a2),
    .ID_Reg_ReadEn2   (e2),
    .ID_Reg_ReadData2 (rd2),
    .Dbg_ReadAddr     (da),
    .Dbg_ReadData     (dbg),
    .Wr_Count         (cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only, updated once per clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'h0;
      m_cnt <= 16'h0;
    end else if (we && wa != 5'd0) begin
      m_regs[wa] <= wd;
      m_cnt      <= m_cnt + 16'd1;
    end
  end

  function automatic logic [31:0] exp_rd(input logic en, input logic [4:0] a);
    if (!en || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_rd1", rd1, exp_rd(e1, a1));
      chk("cmp_rd2", rd2, exp_rd(e2, a2));
      chk("cmp_dbg", dbg, m_regs[da]);
      chk("cmp_cnt", {16'h0, cnt}, {16'h0, m_cnt});
    end
  end

  task automatic set_in(input logic iwe, input logic [4:0] iwa, input logic [31:0] iwd,
                        input logic ie1, input logic [4:0] ia1, input logic ie2,
                        input logic [4:0] ia2, input logic [4:0] ida);
    @(posedge clk);
    #1;
    we = iwe; wa = iwa; wd = iwd;
    e1 = ie1; a1 = ia1; e2 = ie2; a2 = ia2; da = ida;
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0; wa = '0; wd = '0; e1 = 1'b0; a1 = '0; e2 = 1'b0; a2 = '0; da = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state on every address.
    for (int a = 0; a < 32; a++) begin
      set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(a), 5'(a));
      #2;
      chk("rst_rd1", rd1, 32'h0);
      chk("rst_rd2", rd2, 32'h0);
      chk("rst_dbg", dbg, 32'h0);
    end
    chk("rst_cnt", {16'h0, cnt}, 32'h0);

    // Basic write then read.
    set_in(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0, 5'd5);
    #2;
    chk("wr_rd1", rd1, 32'hDEADBEEF);
    chk("wr_dbg", dbg, 32'hDEADBEEF);
    chk("wr_cnt", {16'h0, cnt}, 32'd1);

    // Write to r0 is dropped.
    set_in(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #2;
    chk("r0_rd1", rd1, 32'h0);
    chk("r0_rd2", rd2, 32'h0);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0, 5'd0);
    #2;
    chk("r0_dbg", dbg, 32'h0);
    chk("r0_cnt", {16'h0, cnt}, 32'd1);

    // Same-cycle write/read of r7.
    set_in(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    set_in(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd1", rd1, 32'h22222222);
    chk("byp_rd2", rd2, 32'h22222222);
`else
    chk("byp_rd1", rd1, 32'h11111111);
    chk("byp_rd2", rd2, 32'h11111111);
`endif
    chk("byp_dbg", dbg, 32'h11111111);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7, 5'd7);
    #2;
    chk("post_rd1", rd1, 32'h22222222);
    chk("post_rd2", rd2, 32'h22222222);
    chk("post_dbg", dbg, 32'h22222222);

    // Read enable low, then reset colliding with a write.
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 1'b1, 5'd7, 5'd7);
    #2;
    chk("en0_rd1", rd1, 32'h0);
    chk("en1_rd2", rd2, 32'h22222222);
    set_in(1'b1, 5'd9, 32'hAAAA5555, 1'b1, 5'd9, 1'b1, 5'd7, 5'd9);
    rst = 1'b1;
    #2;
    chk("rstw_rd1", rd1, 32'h0);
    chk("rstw_rd2", rd2, 32'h22222222);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd7, 5'd9);
    rst = 1'b0;
    #2;
    chk("rstw_r9", rd1, 32'h0);
    chk("rstw_r7", rd2, 32'h0);
    chk("rstw_dbg", dbg, 32'h0);
    chk("rstw_cnt", {16'h0, cnt}, 32'd0);

    // Randomised traffic with occasional resets and address collisions.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rwa;
      rwa = 5'($urandom_range(0, 31));
      set_in(1'($urandom_range(0, 3) != 0), rwa, $urandom,
             1'($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0) ? rwa : 5'($urandom),
             1'($urandom_range(0, 7) != 0), ($urandom_range(0, 2) == 0) ? rwa : 5'($urandom),
             ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom));
      rst = ($urandom_range(0, 99) == 0);
    end

    // Counter wrap.
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
    rst = 1'b1;
    set_in(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd1);
    rst = 1'b0;
    for (int n = 0; n < 65535; n++) begin
      set_in(1'b1, 5'd1, 32'(n), 1'b1, 5'd1, 1'b0, 5'd0, 5'd1);
    end
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd1);
    #2;
    chk("wrap_ffff", {16'h0, cnt}, 32'h0000FFFF);
    chk("wrap_r1a", dbg, 32'd65534);
    set_in(1'b1, 5'd1, 32'hCAFEF00D, 1'b1, 5'd1, 1'b0, 5'd0, 5'd1);
    set_in(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd1);
    #2;
    chk("wrap_zero", {16'h0, cnt}, 32'h0);
    chk("wrap_r1b", rd1, 32'hCAFEF00D);
    chk("wrap_dbg", dbg, 32'hCAFEF00D);

    @(posedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
